seq_mult: RTL and testbench

//   Iterative radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits.

---
 rtl/seq_mult.sv | 141 ++++++++++++++
 tb/tb_seq_mult.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mult.sv
// rtl/seq_mult.sv - iterative radix-2 shift-add multiplier, signed/unsigned, valid/ready (optional SEQ_MULT_EARLY_TERM_EN)
module seq_mult #(
    parameter int WIDTH = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sgn,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod,
    output logic               busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc_hi;
    logic               neg;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] step_full;
    logic [2*WIDTH-1:0] res;
    logic               last_step;
`ifdef SEQ_MULT_EARLY_TERM_EN
    // multiplier bits above the one consumed in the current step
    logic [WIDTH-2:0]   mrem;
`endif

    // operand magnitudes; the most negative value maps onto 2^(WIDTH-1), which still fits unsigned
    always_comb begin
        a_mag = (sgn && a[WIDTH-1]) ? -a : a;
        b_mag = (sgn && b[WIDTH-1]) ? -b : b;
    end

    // one add-and-shift step; step_full is {accumulator, multiplier} after this step's shift
    always_comb begin
        sum       = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        step_full = {sum, mplier[WIDTH-1:1]};
`ifdef SEQ_MULT_EARLY_TERM_EN
        last_step = (mrem == '0) || (cnt == LAST);
        res       = step_full >> (LAST - cnt);
`else
        last_step = (cnt == LAST);
        res       = step_full;
`endif
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CALC;
            CALC:    if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // handshake and status outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            CALC:    busy      = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // datapath: capture operands, iterate, and write the signed-corrected product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc_hi <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            prod   <= '0;
`ifdef SEQ_MULT_EARLY_TERM_EN
            mrem   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        acc_hi <= '0;
                        neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        cnt    <= '0;
`ifdef SEQ_MULT_EARLY_TERM_EN
                        mrem   <= b_mag[WIDTH-1:1];
`endif
                    end
                end
                CALC: begin
                    acc_hi <= sum[WIDTH:1];
                    mplier <= {sum[0], mplier[WIDTH-1:1]};
                    cnt    <= cnt + CNT_W'(1);
`ifdef SEQ_MULT_EARLY_TERM_EN
                    mrem   <= mrem >> 1;
`endif
                    if (last_step) begin
                        prod <= neg ? -res : res;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// tb/tb_seq_mult.sv - randomized self-checking bench for seq_mult against an arithmetic model
module tb_seq_mult;

    localparam int W = 25;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           sgn = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] prod;
    logic           busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_mult #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sgn       (sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        longint     sx;
        longint     sy;
        logic [63:0] p;
        sx = s ? longint'($signed(x)) : longint'(x);
        sy = s ? longint'($signed(y)) : longint'(y);
        p  = sx * sy;
        return p[2*W-1:0];
    endfunction

    function automatic int ref_lat(input logic [W-1:0] y, input logic s);
`ifdef SEQ_MULT_EARLY_TERM_EN
        longint mag;
        int     msb;
        mag = s ? longint'($signed(y)) : longint'(y);
        if (mag < 0) mag = -mag;
        msb = -1;
        for (int i = 0; i < W; i++) begin
            if (mag[i]) msb = i;
        end
        return (msb + 1 < 1) ? 1 : msb + 1;
`else
        return W;
`endif
    endfunction

    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                         input int stall, input logic noisy);
        logic [2*W-1:0] exp_p;
        int             lat;
        int             k;
        bit             seen;
        exp_p = ref_prod(xa, xb, xs);
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("in_ready_idle", 64'(in_ready), 64'd1);
        a = xa; b = xb; sgn = xs; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_calc", 64'({busy, in_ready}), 64'b10);
        seen = 1'b0;
        lat = 0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            if (noisy) begin
                in_valid  = 1'($urandom_range(0, 1));
                a         = W'($urandom);
                b         = W'($urandom);
                out_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            if (out_valid) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (!seen) begin
            check("timeout", 64'd0, 64'd1);
            return;
        end
        check("latency", 64'(lat), 64'(ref_lat(xb, xs)));
        check("prod", 64'(prod), 64'(exp_p));
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk); #1;
            check("hold_prod", 64'(prod), 64'(exp_p));
            check("hold_vld_rdy", 64'({out_valid, in_ready, busy}), 64'b100);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("accept", 64'({out_valid, in_ready}), 64'b01);
        check("prod_kept", 64'(prod), 64'(exp_p));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] corner [4];
        corner[0] = '0;
        corner[1] = W'(1);
        corner[2] = W'(25'h1000000);
        corner[3] = W'(25'h1FFFFFF);

        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 64'({in_ready, out_valid, busy}), 64'b100);
        check("rst_prod", 64'(prod), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(25'h1FFFFFF, 25'h1FFFFFF, 1'b0, 0, 1'b0);
        check("t1_const", 64'(prod), 64'h3FFFFFC000001);
        do_op(25'h1000000, 25'h1000000, 1'b0, 0, 1'b0);
        check("t2_unsigned", 64'(prod), 64'h1000000000000);
        do_op(25'h1000000, 25'h1000000, 1'b1, 0, 1'b0);
        check("t2_signed", 64'(prod), 64'h1000000000000);
        do_op(25'h1000000, 25'h0000001, 1'b1, 0, 1'b0);
        check("t2_neg", 64'(prod), 64'h3FFFFFF000000);

        do_op(25'h0001234, 25'h1FEDCBA, 1'b1, 10, 1'b0);

        // abort mid-calculation with an asynchronous reset
        a = 25'h0ABCDEF; b = 25'h1555555; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_state", 64'({in_ready, out_valid, busy}), 64'b100);
        check("rst_mid_prod", 64'(prod), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(25'd3, 25'd5, 1'b0, 0, 1'b0);
        check("after_rst", 64'(prod), 64'hF);

        do_op(25'h0000007, 25'h0000000, 1'b0, 0, 1'b0);
        do_op(25'h0000007, 25'h0000004, 1'b0, 0, 1'b0);
        do_op(25'h1FFFFFF, 25'h1FFFFFF, 1'b1, 0, 1'b0);
        do_op(25'h1000000, 25'h1000000, 1'b1, 2, 1'b0);

        for (int i = 0; i < 300; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, W - 1);
            do_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
